// File: rtl/mtl_raster_timing_if.sv
`default_nettype none
// ============================================================================
//  Module      : mtl_raster_timing_if
//  Description : Scan-position bus for the MTL 800x480 raster timing source.
//                Carries the run request into the timing block and the scan
//                counters, syncs, data-enable, delayed copies and pulses out
//                to the per-pixel generators.
//  Modports    : master - the timing source (drives everything but enable)
//                slave  - a consumer / controller (drives enable)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mtl_raster_timing_if;
  logic        enable;      // run request; low holds the raster idle
  logic [10:0] x_cnt;       // horizontal position
  logic [9:0]  y_cnt;       // vertical position
  logic        hsync_n;     // horizontal sync, active-low
  logic        vsync_n;     // vertical sync, active-low
  logic        de;          // active-area flag
  logic        hsync_n_d;   // hsync_n delayed PIPE_DLY clocks
  logic        vsync_n_d;   // vsync_n delayed PIPE_DLY clocks
  logic        de_d;        // de delayed PIPE_DLY clocks
  logic        frame_start; // one-clock pulse at (0,0)
  logic        line_start;  // one-clock pulse at x_cnt==0
  logic [15:0] frame_cnt;   // completed-frame count

  modport master (
    input  enable,
    output x_cnt, y_cnt, hsync_n, vsync_n, de,
    output hsync_n_d, vsync_n_d, de_d,
    output frame_start, line_start, frame_cnt
  );

  modport slave (
    output enable,
    input  x_cnt, y_cnt, hsync_n, vsync_n, de,
    input  hsync_n_d, vsync_n_d, de_d,
    input  frame_start, line_start, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mtl_raster_timing.sv
`default_nettype none
// ============================================================================
//  Module      : mtl_raster_timing
//  Description : Raster timing source for the MTL 800x480 panel. Owns the
//                scan position (x_cnt/y_cnt, active-first ordering) and
//                produces registered syncs, data-enable, line/frame pulses
//                and PIPE_DLY-delayed copies of the syncs and data-enable.
//  Ports       : clk   - pixel clock
//                reset - asynchronous, active-low reset
//                bus   - mtl_raster_timing_if.master (enable in, rest out)
//  Options     : `define MTL_FRAME_CNT_EN builds the completed-frame counter;
//                otherwise frame_cnt is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mtl_raster_timing #(
  parameter int H_ACT    = 800,
  parameter int H_FP     = 210,
  parameter int H_SYNC   = 30,
  parameter int H_BP     = 16,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 13,
  parameter int V_BP     = 10,
  parameter int PIPE_DLY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mtl_raster_timing_if.master  bus
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] X_ACT  = 11'(H_ACT);
  localparam logic [10:0] HS_ON  = 11'(H_ACT + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_ACT  = 10'(V_ACT);
  localparam logic [9:0]  VS_ON  = 10'(V_ACT + V_FP);
  localparam logic [9:0]  VS_OFF = 10'(V_ACT + V_FP + V_SYNC);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        act_q, act_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic        run_d;
  logic [2:0]  dly_out;     // {hsync_n, vsync_n, de} after the delay line

  // Next-state and next-output computation. Every registered output is
  // derived from the next counter value so it lines up with x_cnt/y_cnt.
  always_comb begin
    state_d = state_q;
    x_d     = '0;
    y_d     = '0;
    case (state_q)
      ST_IDLE: begin
        // Leaving IDLE lands on (0,0), so counters stay at zero here.
        if (bus.enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
        end else begin
          x_d = x_q + 11'd1;
          y_d = y_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    run_d = (state_d == ST_RUN);
    act_d = run_d && (x_d < X_ACT) && (y_d < Y_ACT);
    hs_d  = !(run_d && (x_d >= HS_ON) && (x_d < HS_OFF));
    vs_d  = !(run_d && (y_d >= VS_ON) && (y_d < VS_OFF));
    ls_d  = run_d && (x_d == 11'd0);
    fs_d  = ls_d && (y_d == 10'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      act_q   <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      act_q   <= act_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  // Delay line for the generator-aligned copies. It shifts regardless of
  // state so inactive values flush through after the raster stops.
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign dly_out = {hs_q, vs_q, act_q};
    end else begin : g_dly
      logic [PIPE_DLY-1:0][2:0] dly_q, dly_d;

      always_comb begin
        dly_d[0] = {hs_q, vs_q, act_q};
        for (int i = 1; i < PIPE_DLY; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dly_q <= {PIPE_DLY{3'b110}};
        end else begin
          dly_q <= dly_d;
        end
      end

      assign dly_out = dly_q[PIPE_DLY-1];
    end
  endgenerate

`ifdef MTL_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;
  logic        wrap;

  // Counts the edge that carries the counters from the last pixel back to
  // (0,0); holds through IDLE and wraps naturally at 16 bits.
  always_comb begin
    wrap   = (state_q == ST_RUN) && bus.enable &&
             (x_q == X_LAST) && (y_q == Y_LAST);
    fcnt_d = wrap ? fcnt_q + 16'd1 : fcnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign bus.frame_cnt = fcnt_q;
`else
  assign bus.frame_cnt = '0;
`endif

  assign bus.x_cnt       = x_q;
  assign bus.y_cnt       = y_q;
  assign bus.hsync_n     = hs_q;
  assign bus.vsync_n     = vs_q;
  assign bus.de          = act_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.hsync_n_d   = dly_out[2];
  assign bus.vsync_n_d   = dly_out[1];
  assign bus.de_d        = dly_out[0];

endmodule
`default_nettype wire

// File: tb/tb_mtl_raster_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mtl_raster_timing
//  Description : Directed self-checking bench for mtl_raster_timing.
//                u_a uses the panel timing (800x480, PIPE_DLY=2);
//                u_b uses a 16x12 raster (active 8x6, PIPE_DLY=0) so whole
//                frames fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mtl_raster_timing;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mtl_raster_timing_if a_if ();
  mtl_raster_timing_if b_if ();

  mtl_raster_timing u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.master)
  );

  // Small raster: hsync at x 11..12, vsync at y 8..9, 192 clocks per frame.
  mtl_raster_timing #(
    .H_ACT(8), .H_FP(3), .H_SYNC(2), .H_BP(3),
    .V_ACT(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .PIPE_DLY(0)
  ) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.master)
  );

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
    end
    #1;
  endtask

  int de_cnt, hs_cnt, hs_first, hs_last, ls_cnt, xerr, yerr, perr;
  int fs_cnt, fs_prev, fs_gap, vs_cnt, vs_bad, hs_bad, de_bad, p0err, xm, ym;
  logic [2:0] p1, p2, cur;
  logic [15:0] exp_fcnt;

  initial begin
    checks = 0;
    errors = 0;

    // ---------------- reset with enable held high ----------------
    reset = 1'b0;
    a_if.enable = 1'b1;
    b_if.enable = 1'b0;
    step(3);
    chk("rst_x",   32'(a_if.x_cnt), 0);
    chk("rst_y",   32'(a_if.y_cnt), 0);
    chk("rst_hs",  32'(a_if.hsync_n), 1);
    chk("rst_vs",  32'(a_if.vsync_n), 1);
    chk("rst_de",  32'(a_if.de), 0);
    chk("rst_fs",  32'(a_if.frame_start), 0);
    chk("rst_ls",  32'(a_if.line_start), 0);
    chk("rst_hsd", 32'(a_if.hsync_n_d), 1);
    chk("rst_vsd", 32'(a_if.vsync_n_d), 1);
    chk("rst_ded", 32'(a_if.de_d), 0);
    chk("rst_fc",  32'(a_if.frame_cnt), 0);

    // ---------------- idle after release ----------------
    a_if.enable = 1'b0;
    reset = 1'b1;
    step(2);
    chk("idle_x",  32'(a_if.x_cnt), 0);
    chk("idle_de", 32'(a_if.de), 0);
    chk("idle_fs", 32'(a_if.frame_start), 0);

    // ---------------- first RUN cycle presents (0,0) ----------------
    a_if.enable = 1'b1;
    step(1);
    chk("start_x",  32'(a_if.x_cnt), 0);
    chk("start_y",  32'(a_if.y_cnt), 0);
    chk("start_fs", 32'(a_if.frame_start), 1);
    chk("start_ls", 32'(a_if.line_start), 1);
    chk("start_de", 32'(a_if.de), 1);
    chk("start_hs", 32'(a_if.hsync_n), 1);

    // ---------------- one full line ----------------
    p1 = 3'b110;
    p2 = 3'b110;
    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    ls_cnt = 0; xerr = 0; yerr = 0; perr = 0;
    for (int i = 0; i < 1056; i++) begin
      if (a_if.x_cnt !== 11'(i)) xerr++;
      if (a_if.y_cnt !== 10'd0) yerr++;
      if (a_if.de) de_cnt++;
      if (!a_if.hsync_n) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (a_if.line_start) ls_cnt++;
      cur = {a_if.hsync_n, a_if.vsync_n, a_if.de};
      if ({a_if.hsync_n_d, a_if.vsync_n_d, a_if.de_d} !== p2) perr++;
      p2 = p1;
      p1 = cur;
      step(1);
    end
    chk("line_xseq",   32'(xerr), 0);
    chk("line_y0",     32'(yerr), 0);
    chk("line_de",     32'(de_cnt), 800);
    chk("line_hs",     32'(hs_cnt), 30);
    chk("line_hs1st",  32'(hs_first), 1010);
    chk("line_hslast", 32'(hs_last), 1039);
    chk("line_ls",     32'(ls_cnt), 1);
    chk("pipe2",       32'(perr), 0);
    chk("wrap_x",      32'(a_if.x_cnt), 0);
    chk("wrap_y",      32'(a_if.y_cnt), 1);
    chk("wrap_ls",     32'(a_if.line_start), 1);
    chk("wrap_fs",     32'(a_if.frame_start), 0);

    // ---------------- enable drop mid-line ----------------
    step(300);
    chk("drop_pre_x", 32'(a_if.x_cnt), 300);
    chk("drop_pre_y", 32'(a_if.y_cnt), 1);
    a_if.enable = 1'b0;
    step(1);
    chk("drop_x",  32'(a_if.x_cnt), 0);
    chk("drop_y",  32'(a_if.y_cnt), 0);
    chk("drop_de", 32'(a_if.de), 0);
    chk("drop_hs", 32'(a_if.hsync_n), 1);
    chk("drop_vs", 32'(a_if.vsync_n), 1);
    chk("drop_ls", 32'(a_if.line_start), 0);
    a_if.enable = 1'b1;
    step(1);
    chk("rerun_fs", 32'(a_if.frame_start), 1);
    chk("rerun_x",  32'(a_if.x_cnt), 0);
    chk("rerun_de", 32'(a_if.de), 1);

    // ---------------- frame timing on the small raster ----------------
    b_if.enable = 1'b1;
    step(1);
    fs_cnt = 0; fs_prev = -1; fs_gap = -1; vs_cnt = 0; vs_bad = 0;
    hs_bad = 0; de_bad = 0; p0err = 0; xerr = 0; yerr = 0;
    for (int i = 0; i < 384; i++) begin
      xm = i % 16;
      ym = (i / 16) % 12;
      if (b_if.x_cnt !== 11'(xm)) xerr++;
      if (b_if.y_cnt !== 10'(ym)) yerr++;
      if (!b_if.vsync_n) vs_cnt++;
      if ((!b_if.vsync_n) !== (ym >= 8 && ym <= 9)) vs_bad++;
      if ((!b_if.hsync_n) !== (xm >= 11 && xm <= 12)) hs_bad++;
      if (b_if.de !== (xm < 8 && ym < 6)) de_bad++;
      if ({b_if.hsync_n_d, b_if.vsync_n_d, b_if.de_d} !==
          {b_if.hsync_n, b_if.vsync_n, b_if.de}) p0err++;
      if (b_if.frame_start) begin
        if (fs_prev >= 0) fs_gap = i - fs_prev;
        fs_prev = i;
        fs_cnt++;
      end
      step(1);
    end
    chk("frm_x",     32'(xerr), 0);
    chk("frm_y",     32'(yerr), 0);
    chk("frm_vscnt", 32'(vs_cnt), 64);
    chk("frm_vspos", 32'(vs_bad), 0);
    chk("frm_hspos", 32'(hs_bad), 0);
    chk("frm_de",    32'(de_bad), 0);
    chk("frm_fscnt", 32'(fs_cnt), 2);
    chk("frm_fsgap", 32'(fs_gap), 192);
    chk("pipe0",     32'(p0err), 0);

    // Third frame completes; counters back at (0,0).
    step(192);
`ifdef MTL_FRAME_CNT_EN
    exp_fcnt = 16'd3;
`else
    exp_fcnt = 16'd0;
`endif
    chk("fcnt3",    32'(b_if.frame_cnt), 32'(exp_fcnt));
    chk("fcnt3_x",  32'(b_if.x_cnt), 0);
    chk("fcnt3_fs", 32'(b_if.frame_start), 1);
    chk("fcnt_a",   32'(a_if.frame_cnt), 0);

    // ---------------- asynchronous reset mid-frame ----------------
    step(69);
    chk("mid_x",  32'(b_if.x_cnt), 5);
    chk("mid_y",  32'(b_if.y_cnt), 4);
    chk("mid_de", 32'(b_if.de), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_x",   32'(b_if.x_cnt), 0);
    chk("arst_y",   32'(b_if.y_cnt), 0);
    chk("arst_de",  32'(b_if.de), 0);
    chk("arst_hs",  32'(b_if.hsync_n), 1);
    chk("arst_vs",  32'(b_if.vsync_n), 1);
    chk("arst_fc",  32'(b_if.frame_cnt), 0);
    chk("arst_ded", 32'(b_if.de_d), 0);
    chk("arst_ax",  32'(a_if.x_cnt), 0);
    chk("arst_ahd", 32'(a_if.hsync_n_d), 1);
    chk("arst_add", 32'(a_if.de_d), 0);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
